// File: rtl/cmd_dispatcher.sv
// Command dispatcher: decodes received UART command bytes, enables one handler
// channel at a time, muxes its tx requests to the UART and NAKs unknown commands.
module cmd_dispatcher #(
  parameter int                N_CH      = 9,
  parameter logic [N_CH*8-1:0] CMD_TABLE = {8'h72, 8'h71, 8'h32, 8'h31, 8'h25,
                                            8'h24, 8'h23, 8'h22, 8'h21},
  parameter int                TIMEOUT   = 50_000_000,
  parameter int                TO_W      = 26,
  parameter logic [7:0]        NAK_BYTE  = 8'h15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              tx_active,
  input  logic [N_CH-1:0]   ch_done,
  input  logic [N_CH*8-1:0] ch_tx_data,
  input  logic [N_CH-1:0]   ch_tx_start,
  output logic [N_CH-1:0]   ch_activate,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic [7:0]        state_code,
  output logic              timeout_flag,
  output logic              nak_flag
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DISPATCH = 3'd1,
    S_NAK      = 3'd2,
    S_DRAIN    = 3'd3
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
  localparam logic [TO_W-1:0] TO_MAX  = '1;

  state_t            state, state_n;
  logic [TO_W-1:0]   to_cnt, to_cnt_n;
  logic [N_CH-1:0]   act_n;
  logic [7:0]        tx_data_n, code_n;
  logic              tx_start_n, to_flag_n, nak_flag_n;
  logic              match_any;
  logic [N_CH-1:0]   match_oh;
  logic [7:0]        sel_data;
  logic              sel_start;
  logic              done_hit, timeout_hit;

  // Descending scan so the lowest matching channel index overrides the rest.
  always_comb begin
    match_any = 1'b0;
    match_oh  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (CMD_TABLE[i*8 +: 8] == rx_data) begin
        match_any   = 1'b1;
        match_oh    = '0;
        match_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_start = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_activate[i]) begin
        sel_data  = ch_tx_data[i*8 +: 8];
        sel_start = ch_tx_start[i];
      end
    end
  end

  assign done_hit    = |(ch_done & ch_activate);
  assign timeout_hit = (TIMEOUT != 0) && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_DRAIN;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (rx_ready) state_n = match_any ? S_DISPATCH : S_NAK;
      S_DISPATCH: if (done_hit || timeout_hit) state_n = S_DRAIN;
      S_NAK:      if (tx_start && tx_active) state_n = S_DRAIN;
      S_DRAIN:    if (!rx_ready && !tx_active) state_n = S_IDLE;
      default:    state_n = S_DRAIN;
    endcase
  end

  // Next values for the registered outputs; tx_start doubles as the NAK "sending" marker.
  always_comb begin
    act_n      = ch_activate;
    tx_data_n  = tx_data;
    tx_start_n = 1'b0;
    code_n     = state_code;
    to_flag_n  = 1'b0;
    nak_flag_n = 1'b0;
    to_cnt_n   = to_cnt;
    case (state)
      S_IDLE: begin
        act_n  = '0;
        code_n = 8'h00;
        if (rx_ready) begin
          if (match_any) begin
            act_n    = match_oh;
            code_n   = rx_data;
            to_cnt_n = '0;
          end else begin
            nak_flag_n = 1'b1;
            code_n     = 8'hEE;
          end
        end
      end
      S_DISPATCH: begin
        if (to_cnt != TO_MAX) to_cnt_n = to_cnt + TO_W'(1);
        if (done_hit) begin
          act_n  = '0;
          code_n = 8'h01;
        end else if (timeout_hit) begin
          act_n     = '0;
          code_n    = 8'h01;
          to_flag_n = 1'b1;
        end else begin
          tx_data_n  = sel_data;
          tx_start_n = sel_start;
        end
      end
      S_NAK: begin
        act_n = '0;
        if (tx_start && tx_active) begin
          code_n = 8'h01;
        end else if (!tx_active) begin
          tx_start_n = 1'b1;
          tx_data_n  = NAK_BYTE;
        end
      end
      S_DRAIN: begin
        act_n  = '0;
        code_n = (!rx_ready && !tx_active) ? 8'h00 : 8'h01;
      end
      default: begin
        act_n  = '0;
        code_n = 8'h01;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_activate  <= '0;
      tx_data      <= 8'h00;
      tx_start     <= 1'b0;
      state_code   <= 8'h01;
      timeout_flag <= 1'b0;
      nak_flag     <= 1'b0;
      to_cnt       <= '0;
    end else begin
      ch_activate  <= act_n;
      tx_data      <= tx_data_n;
      tx_start     <= tx_start_n;
      state_code   <= code_n;
      timeout_flag <= to_flag_n;
      nak_flag     <= nak_flag_n;
      to_cnt       <= to_cnt_n;
    end
  end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Bench for cmd_dispatcher: directed scenarios with literal expectations, then
// random traffic compared every cycle against a transaction-level model.
module tb_cmd_dispatcher;

  localparam int                N_CH      = 9;
  localparam logic [N_CH*8-1:0] TABLE_LIT = {8'h72, 8'h71, 8'h32, 8'h31, 8'h25,
                                             8'h24, 8'h23, 8'h22, 8'h21};
  localparam int                TIMEOUT_TB = 10;
  localparam logic [7:0]        NAK_TB     = 8'h15;

  localparam int MD_IDLE = 0, MD_BUSY = 1, MD_NAK = 2, MD_DRAIN = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data     = '0;
  logic              rx_ready    = 1'b0;
  logic              tx_active   = 1'b0;
  logic [N_CH-1:0]   ch_done     = '0;
  logic [N_CH*8-1:0] ch_tx_data  = '0;
  logic [N_CH-1:0]   ch_tx_start = '0;
  logic [N_CH-1:0]   ch_activate;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic [7:0]        state_code;
  logic              timeout_flag;
  logic              nak_flag;

  logic [N_CH*8-1:0] tbl = TABLE_LIT;
  int n_cmp = 0;
  int n_bad = 0;
  logic cmp_on = 1'b0;

  // Model state: which phase the block is in, the serving channel and how many
  // cycles it has been enabled so far; e_* are the outputs it must show.
  int              m_mode = MD_DRAIN;
  int              m_ch   = 0;
  int              m_age  = 0;
  logic [N_CH-1:0] e_act  = '0;
  logic [7:0]      e_txd  = 8'h00;
  logic            e_txs  = 1'b0;
  logic [7:0]      e_code = 8'h01;
  logic            e_to   = 1'b0;
  logic            e_nak  = 1'b0;

  cmd_dispatcher #(
    .N_CH(N_CH), .CMD_TABLE(TABLE_LIT), .TIMEOUT(TIMEOUT_TB), .TO_W(4), .NAK_BYTE(NAK_TB)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready), .tx_active(tx_active),
    .ch_done(ch_done), .ch_tx_data(ch_tx_data), .ch_tx_start(ch_tx_start),
    .ch_activate(ch_activate), .tx_data(tx_data), .tx_start(tx_start),
    .state_code(state_code), .timeout_flag(timeout_flag), .nak_flag(nak_flag)
  );

  always #5 clk = ~clk;

  function automatic int lookup(input logic [7:0] d);
    for (int i = 0; i < N_CH; i++) if (tbl[i*8 +: 8] == d) return i;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = MD_DRAIN; m_ch = 0; m_age = 0;
      e_act = '0; e_txd = 8'h00; e_txs = 1'b0; e_code = 8'h01; e_to = 1'b0; e_nak = 1'b0;
    end else begin
      e_to  = 1'b0;
      e_nak = 1'b0;
      case (m_mode)
        MD_IDLE: begin
          e_act = '0;
          e_txs = 1'b0;
          if (!rx_ready) e_code = 8'h00;
          else begin
            m_ch = lookup(rx_data);
            if (m_ch >= 0) begin
              m_mode = MD_BUSY; m_age = 1; e_act[m_ch] = 1'b1; e_code = rx_data;
            end else begin
              m_mode = MD_NAK; e_nak = 1'b1; e_code = 8'hEE;
            end
          end
        end
        MD_BUSY: begin
          if (ch_done[m_ch] || m_age == TIMEOUT_TB) begin
            e_to   = !ch_done[m_ch];
            m_mode = MD_DRAIN; e_act = '0; e_txs = 1'b0; e_code = 8'h01;
          end else begin
            m_age = m_age + 1;
            e_txd = ch_tx_data[m_ch*8 +: 8];
            e_txs = ch_tx_start[m_ch];
          end
        end
        MD_NAK: begin
          if (e_txs && tx_active) begin
            m_mode = MD_DRAIN; e_txs = 1'b0; e_code = 8'h01;
          end else if (!tx_active) begin
            e_txs = 1'b1; e_txd = NAK_TB;
          end
        end
        default: begin
          e_act = '0;
          e_txs = 1'b0;
          if (!rx_ready && !tx_active) begin m_mode = MD_IDLE; e_code = 8'h00; end
          else e_code = 8'h01;
        end
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      checkOutput("ch_activate", ch_activate, e_act);
      checkOutput("tx_data", tx_data, e_txd);
      checkOutput("tx_start", tx_start, e_txs);
      checkOutput("state_code", state_code, e_code);
      checkOutput("timeout_flag", timeout_flag, e_to);
      checkOutput("nak_flag", nak_flag, e_nak);
      checkOutput("onehot", 72'($countones(ch_activate) <= 1), 72'(1));
    end
  end

  // Drives one cycle's inputs, then returns 2 time units after the edge that sampled them.
  task automatic applyStimulus(input logic [7:0] d, input logic rdy, input logic [N_CH-1:0] done,
                               input logic txa, input logic [N_CH*8-1:0] txd, input logic [N_CH-1:0] txs);
    rx_data = d; rx_ready = rdy; ch_done = done; tx_active = txa;
    ch_tx_data = txd; ch_tx_start = txs;
    @(posedge clk);
    #2;
  endtask

  task automatic idleTick();
    applyStimulus(8'h00, 1'b0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $finish;
  end

  initial begin
    int high_cycles;
    int to_pulses;
    int k;
    logic [N_CH*8-1:0] rtxd;
    logic [N_CH-1:0]   rdone;

    rst = 1'b1;
    cmp_on = 1'b1;
    @(posedge clk); #2;
    checkOutput("reset_act", ch_activate, 72'h0);
    checkOutput("reset_code", state_code, 72'h01);
    checkOutput("reset_txd", tx_data, 72'h00);
    @(posedge clk); #2;
    rst = 1'b0;
    idleTick();
    checkOutput("drain_to_idle", state_code, 72'h00);

    applyStimulus(8'h22, 1'b1, '0, 1'b0, '0, '0);
    checkOutput("d22_act", ch_activate, 72'h002);
    checkOutput("d22_code", state_code, 72'h22);
    applyStimulus(8'h00, 1'b0, 9'h002, 1'b0, '0, '0);
    checkOutput("d22_done_act", ch_activate, 72'h0);
    checkOutput("d22_done_code", state_code, 72'h01);
    idleTick();
    checkOutput("d22_idle_code", state_code, 72'h00);

    applyStimulus(8'h25, 1'b1, '0, 1'b0, '0, '0);
    checkOutput("ch4_act", ch_activate, 72'h010);
    applyStimulus(8'h00, 1'b0, 9'h001, 1'b0, 72'hA5 << 32, 9'h011);
    checkOutput("ch4_txd", tx_data, 72'hA5);
    checkOutput("ch4_txs", tx_start, 72'h1);
    checkOutput("ch4_ignore_done0", ch_activate, 72'h010);
    applyStimulus(8'h00, 1'b0, 9'h010, 1'b0, '0, 9'h001);
    checkOutput("ch4_done_txs", tx_start, 72'h0);
    idleTick();

    applyStimulus(8'h99, 1'b1, '0, 1'b0, '0, '0);
    checkOutput("nak_flag", nak_flag, 72'h1);
    checkOutput("nak_code", state_code, 72'hEE);
    idleTick();
    checkOutput("nak_txs", tx_start, 72'h1);
    checkOutput("nak_txd", tx_data, 72'h15);
    checkOutput("nak_flag_once", nak_flag, 72'h0);
    idleTick();
    checkOutput("nak_txs_hold", tx_start, 72'h1);
    applyStimulus(8'h00, 1'b0, '0, 1'b1, '0, '0);
    checkOutput("nak_txs_drop", tx_start, 72'h0);
    checkOutput("nak_drain_code", state_code, 72'h01);
    idleTick();

    applyStimulus(8'h21, 1'b1, '0, 1'b0, '0, '0);
    high_cycles = (ch_activate != '0) ? 1 : 0;
    to_pulses = 0;
    for (int c = 0; c < 20; c++) begin
      idleTick();
      if (ch_activate != '0) high_cycles++;
      if (timeout_flag) to_pulses++;
    end
    checkOutput("to_high_cycles", 72'(high_cycles), 72'd10);
    checkOutput("to_pulses", 72'(to_pulses), 72'd1);

    applyStimulus(8'h21, 1'b1, '0, 1'b0, '0, '0);
    for (int c = 0; c < 9; c++) idleTick();
    checkOutput("to_edge_still_act", ch_activate, 72'h001);
    applyStimulus(8'h00, 1'b0, 9'h001, 1'b0, '0, '0);
    checkOutput("to_edge_act", ch_activate, 72'h0);
    checkOutput("to_edge_noflag", timeout_flag, 72'h0);
    checkOutput("to_edge_code", state_code, 72'h01);
    idleTick();

    applyStimulus(8'h71, 1'b1, '0, 1'b0, '0, '0);
    idleTick();
    checkOutput("rst71_act", ch_activate, 72'h080);
    rst = 1'b1;
    #1;
    checkOutput("rst71_act_async", ch_activate, 72'h0);
    checkOutput("rst71_code_async", state_code, 72'h01);
    @(posedge clk); #2;
    rst = 1'b0;
    idleTick();
    applyStimulus(8'h71, 1'b1, '0, 1'b0, '0, '0);
    checkOutput("rst71_again", ch_activate, 72'h080);
    idleTick();

    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(199) == 0);
      for (int b = 0; b < N_CH; b++) begin
        rtxd[b*8 +: 8] = 8'($urandom);
        rdone[b] = ($urandom_range(9) == 0);
      end
      k = $urandom_range(N_CH - 1);
      applyStimulus(($urandom_range(1) == 1) ? tbl[k*8 +: 8] : 8'($urandom),
                    ($urandom_range(3) == 0), rdone, ($urandom_range(2) == 0),
                    rtxd, N_CH'($urandom));
    end
    rst = 1'b0;
    idleTick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
